// File: rtl/fire2_squeeze_ofm_writer_pkg.sv
// Shared types and default geometry for the fire2_squeeze output feature-map writer.
package fire2_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CH     = 16;
    localparam int unsigned WOUT   = 64;
    localparam int unsigned PIX    = WOUT * WOUT;
    localparam int unsigned ADDR_W = $clog2(CH * PIX);

    typedef logic [WIDTH-1:0] word_t;
    typedef word_t [0:CH-1]   pix_vec_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/fire2_squeeze_ofm_writer_buf.sv
// Two-slot ping-pong pixel buffer: one slot fills from the conv stage while the other drains.
module ofm_pingpong_buf
    import fire2_pkg::*;
#(
    parameter int unsigned CH    = 16,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data [0:CH-1],
    input  logic             pop,
    input  logic [CH_W-1:0]  rd_ch,
    output logic             full,
    output logic             head_valid,
    output logic             other_valid,
    output logic [WIDTH-1:0] head_word
);

    logic [WIDTH-1:0] slot_q [0:1][0:CH-1];
    logic [1:0]       valid_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;

    // Push only targets a free slot and pop only the head, so a same-edge
    // push and pop always touch different slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int unsigned c = 0; c < CH; c++) begin
                slot_q[wr_ptr_q][c] <= push_data[c];
            end
        end
    end

    always_comb begin
        full        = &valid_q;
        head_valid  = valid_q[rd_ptr_q];
        other_valid = valid_q[~rd_ptr_q];
        head_word   = slot_q[rd_ptr_q][rd_ch];
    end

endmodule

// File: rtl/fire2_squeeze_ofm_writer.sv
// Serialises each CH-wide ReLU'd pixel into the feature-map RAM in channel-major order
// and signals ram_feedback_o once the full WOUT x WOUT x CH map has been stored.
module fire2_squeeze_ofm_writer
    import fire2_pkg::*;
#(
    parameter  int unsigned WOUT   = fire2_pkg::WOUT,
    parameter  int unsigned CH     = fire2_pkg::CH,
    parameter  int unsigned WIDTH  = fire2_pkg::WIDTH,
    localparam int unsigned ADDR_W = $clog2(CH * WOUT * WOUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_i,
    input  logic [WIDTH-1:0]  ofm_i [0:CH-1],
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [WIDTH-1:0]  wr_data_o,
    output logic              ram_feedback_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int unsigned NPIX  = WOUT * WOUT;
    localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q;
    logic [PIX_W-1:0]   pix_q;
    logic               fin_q;

    logic               accept, push, drop, issue, pop;
    logic               last_ch, last_pix;
    logic               full, head_valid, other_valid;
    logic [WIDTH-1:0]   head_word, issue_word;

    ofm_pingpong_buf #(
        .CH    (CH),
        .WIDTH (WIDTH),
        .CH_W  (CH_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (ofm_i),
        .pop         (pop),
        .rd_ch       (ch_q),
        .full        (full),
        .head_valid  (head_valid),
        .other_valid (other_valid),
        .head_word   (head_word)
    );

    // A capture into an empty buffer issues channel 0 straight from ofm_i so
    // the first write lands one cycle after the sample pulse.
    always_comb begin
        accept     = sample_i && (state_q != DONE);
        push       = accept && !full;
        drop       = accept && full;
        issue      = (state_q == DRAIN) || ((state_q == IDLE) && (head_valid || push));
        last_ch    = (ch_q == CH_W'(CH - 1));
        last_pix   = (pix_q == PIX_W'(NPIX - 1));
        pop        = issue && last_ch;
        issue_word = head_valid ? head_word : ofm_i[ch_q];

        state_d = state_q;
        if (issue) begin
            if (pop && last_pix) begin
                state_d = DONE;
            end else if (pop && !(other_valid || push)) begin
                state_d = IDLE;
            end else begin
                state_d = DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ch_q           <= '0;
            pix_q          <= '0;
            fin_q          <= 1'b0;
            wr_en_o        <= 1'b0;
            wr_addr_o      <= '0;
            wr_data_o      <= '0;
            ram_feedback_o <= 1'b0;
            done_o         <= 1'b0;
            overrun_o      <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en_o <= issue;
            if (issue) begin
                wr_data_o <= issue_word;
                wr_addr_o <= ADDR_W'(ch_q) * ADDR_W'(NPIX) + ADDR_W'(pix_q);
                ch_q      <= last_ch ? '0 : ch_q + 1'b1;
            end
            if (pop) begin
                pix_q <= pix_q + 1'b1;
            end
            // Completion is flagged on the cycle after the final word is on the bus.
            fin_q          <= pop && last_pix;
            ram_feedback_o <= fin_q;
            if (fin_q) begin
                done_o <= 1'b1;
            end
            if (drop) begin
                overrun_o <= 1'b1;
            end
        end
    end

    assign busy_o = head_valid | other_valid | wr_en_o;

endmodule
